// File: rtl/apb4_arb_pkg.sv
// rtl/apb4_arb_pkg.sv - shared types and default widths for the APB4 master arbiter
package apb4_arb_pkg;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_STRB_WIDTH = APB_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Captured transfer; sized for the widest supported bus, narrower
  // configurations use the low bits.
  typedef struct packed {
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic                      write;
    logic [APB_DATA_WIDTH-1:0] wdata;
    logic [APB_STRB_WIDTH-1:0] strb;
    logic [2:0]                prot;
  } apb_req_s;

endpackage

// File: rtl/apb4_master_arbiter_rr_arbiter.sv
// rtl/apb4_master_arbiter_rr_arbiter.sv - combinational round-robin grant
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic found;

  // Scan from the requester after the last winner, wrapping once round.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      int cand;
      cand = (int'(last_i) + off) % NUM_REQ;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IDX_W'(cand);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/apb4_master_arbiter.sv
// rtl/apb4_master_arbiter.sv - round-robin sharing of one APB4 master port
module apb4_master_arbiter
  import apb4_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            PCLK,
  input  logic                            PRESET,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb,
  input  logic [NUM_REQ*3-1:0]            req_prot,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            rsp_err,
  output logic                            PSEL,
  output logic                            PENABLE,
  output logic                            PWRITE,
  output logic [ADDR_WIDTH-1:0]           PADDR,
  output logic [DATA_WIDTH-1:0]           PWDATA,
  output logic [DATA_WIDTH/8-1:0]         PSTRB,
  output logic [2:0]                      PPROT,
  input  logic                            PREADY,
  input  logic                            PSLVERR,
  input  logic [DATA_WIDTH-1:0]           PRDATA
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 2);
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  apb_state_e         state_q, state_d;
  apb_req_s           cap_q, cap_d;
  // Last accepted requester; it is also the owner of the transfer in flight.
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               timeout;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
    .req_i   (req_valid),
    .last_i  (last_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  // This ACCESS cycle would be the TIMEOUT_CYCLES-th without PREADY.
  assign timeout = (TIMEOUT_CYCLES > 0) && !PREADY && (cnt_q == CNT_W'(TO_LAST));

  // Next-state, capture and the handshake pulses.
  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (grant_any) begin
          req_ready   = grant;
          last_d      = grant_idx;
          cap_d.addr  = APB_ADDR_WIDTH'(req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH]);
          cap_d.write = req_write[grant_idx];
          cap_d.wdata = APB_DATA_WIDTH'(req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH]);
          cap_d.strb  = req_write[grant_idx]
                        ? APB_STRB_WIDTH'(req_strb[grant_idx*STRB_W +: STRB_W]) : '0;
          cap_d.prot  = req_prot[grant_idx*3 +: 3];
          psel_d      = 1'b1;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY || timeout) begin
          rsp_valid = NUM_REQ'(1) << last_q;
          rsp_rdata = (PREADY && !cap_q.write) ? PRDATA : '0;
          rsp_err   = PREADY ? PSLVERR : 1'b1;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
    // A transfer cut short by reset is dropped silently.
    if (PRESET) begin
      req_ready = '0;
      rsp_valid = '0;
      rsp_rdata = '0;
      rsp_err   = 1'b0;
    end
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cap_q     <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
    end
  end

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = cap_q.write;
  assign PADDR   = cap_q.addr[ADDR_WIDTH-1:0];
  assign PWDATA  = cap_q.wdata[DATA_WIDTH-1:0];
  assign PSTRB   = cap_q.strb[STRB_W-1:0];
  assign PPROT   = cap_q.prot;

endmodule
